// File: rtl/vga_pkg.sv
// vga_pkg: constants shared by the VGA frame analyzer.
//   - default VGA 640x480 timing offsets measured from the sync assertion edges
//   - bit positions inside the TinyVGA PMOD byte {hsync, B0, G0, R0, vsync, B1, G1, R1}
//   - a saturating 10-bit increment used by the sync counters
package vga_pkg;

    localparam int H_START_DEF  = 144;
    localparam int V_START_DEF  = 35;
    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    localparam int HSYNC_BIT = 7;
    localparam int VSYNC_BIT = 3;

    // All six colour bits (B0 G0 R0 in [6:4], B1 G1 R1 in [2:0]).
    localparam logic [7:0] COLOUR_MASK = 8'b0111_0111;

    // Syncs high (idle) with colours set; the reset value of the input register.
    localparam logic [7:0] PMOD_RESET = 8'hFF;

    localparam logic [9:0]  CNT_MAX = 10'd1023;
    localparam logic [18:0] LIT_MAX = 19'h7FFFF;

    function automatic logic [9:0] sat_inc10(input logic [9:0] v);
        return (v == CNT_MAX) ? v : v + 10'd1;
    endfunction

endpackage

// File: rtl/vga_timing_recover.sv
// vga_timing_recover: recovers pixel/line position from the TinyVGA sync bits.
//   clk, rst_n  : clock, asynchronous active-low reset
//   vga_in      : raw PMOD byte
//   pix         : registered PMOD byte (the only copy the rest of the design uses)
//   hs_edge     : registered hsync went 1->0 (pix is the first sample of a line)
//   vs_edge     : registered vsync went 1->0
//   hcnt, vcnt  : position of the sample currently in pix (0 on the edge cycle)
//   h_locked    : two consecutive identical line lengths below 1023
module vga_timing_recover
    import vga_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] vga_in,
    output logic [7:0] pix,
    output logic       hs_edge,
    output logic       vs_edge,
    output logic [9:0] hcnt,
    output logic [9:0] vcnt,
    output logic       h_locked
);

    logic [7:0]  in_q, in_d;
    logic        hs_prev_q, hs_prev_d;
    logic        vs_prev_q, vs_prev_d;
    // hcnt_q/vcnt_q hold the position of the previous sample; the _d values
    // are the position of the sample now in in_q.
    logic [9:0]  hcnt_q, hcnt_d;
    logic [9:0]  vcnt_q, vcnt_d;
    logic [10:0] line_len_q, line_len_d;
    logic [10:0] new_len;
    logic        locked_q, locked_d;

    always_comb begin
        in_d       = vga_in;
        hs_prev_d  = in_q[HSYNC_BIT];
        vs_prev_d  = in_q[VSYNC_BIT];
        hs_edge    = hs_prev_q & ~in_q[HSYNC_BIT];
        vs_edge    = vs_prev_q & ~in_q[VSYNC_BIT];
        new_len    = {1'b0, hcnt_q} + 11'd1;
        line_len_d = line_len_q;
        locked_d   = locked_q;

        hcnt_d = hs_edge ? 10'd0 : sat_inc10(hcnt_q);

        // vsync edge wins over a coincident hsync edge.
        if (vs_edge) begin
            vcnt_d = 10'd0;
        end else if (hs_edge) begin
            vcnt_d = sat_inc10(vcnt_q);
        end else begin
            vcnt_d = vcnt_q;
        end

        if (hs_edge) begin
            line_len_d = new_len;
            locked_d   = (new_len == line_len_q) && (new_len < 11'd1023);
        end else if (hcnt_d == CNT_MAX) begin
            locked_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q       <= PMOD_RESET;
            hs_prev_q  <= 1'b1;
            vs_prev_q  <= 1'b1;
            hcnt_q     <= CNT_MAX;
            vcnt_q     <= CNT_MAX;
            line_len_q <= '0;
            locked_q   <= 1'b0;
        end else begin
            in_q       <= in_d;
            hs_prev_q  <= hs_prev_d;
            vs_prev_q  <= vs_prev_d;
            hcnt_q     <= hcnt_d;
            vcnt_q     <= vcnt_d;
            line_len_q <= line_len_d;
            locked_q   <= locked_d;
        end
    end

    assign pix      = in_q;
    assign hcnt     = hcnt_d;
    assign vcnt     = vcnt_d;
    assign h_locked = locked_q;

endmodule

// File: rtl/vga_frame_analyzer.sv
// vga_frame_analyzer: per-frame bounding box and lit-pixel count of a TinyVGA stream.
//   clk, rst_n        : clock, asynchronous active-low reset
//   vga_in            : PMOD byte {hsync, B0, G0, R0, vsync, B1, G1, R1}, syncs active-low
//   bbox_left/top/right/bottom : extent of lit pixels in the last published frame (0 if empty)
//   lit_count         : lit active pixels in the last published frame (saturating)
//   frame_count       : published frames, wraps at 256
//   frame_valid       : one-cycle pulse on the cycle the outputs change; no handshake,
//                       a consumer that wants the values must take them on that cycle
//   frame_empty       : last published frame had no lit pixel
//   h_locked          : line period stable
module vga_frame_analyzer
    import vga_pkg::*;
#(
    parameter int H_START  = H_START_DEF,
    parameter int V_START  = V_START_DEF,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  vga_in,
    output logic [9:0]  bbox_left,
    output logic [9:0]  bbox_top,
    output logic [9:0]  bbox_right,
    output logic [9:0]  bbox_bottom,
    output logic [18:0] lit_count,
    output logic [7:0]  frame_count,
    output logic        frame_valid,
    output logic        frame_empty,
    output logic        h_locked
);

    localparam logic [9:0]  H_LO  = 10'(H_START);
    localparam logic [9:0]  V_LO  = 10'(V_START);
    localparam logic [10:0] H_END = 11'(H_START + H_ACTIVE);
    localparam logic [10:0] V_END = 11'(V_START + V_ACTIVE);

    logic [7:0] pix;
    logic       hs_edge, vs_edge;
    logic [9:0] hcnt, vcnt;
    logic [9:0] x, y;
    logic       active, lit, acc_empty;

    vga_timing_recover u_timing (
        .clk      (clk),
        .rst_n    (rst_n),
        .vga_in   (vga_in),
        .pix      (pix),
        .hs_edge  (hs_edge),
        .vs_edge  (vs_edge),
        .hcnt     (hcnt),
        .vcnt     (vcnt),
        .h_locked (h_locked)
    );

    assign active = (hcnt >= H_LO) && ({1'b0, hcnt} < H_END) &&
                    (vcnt >= V_LO) && ({1'b0, vcnt} < V_END);
    assign lit    = active && ((pix & COLOUR_MASK) != 8'd0);
    assign x      = hcnt - H_LO;
    assign y      = vcnt - V_LO;

    logic [9:0]  min_x_q, min_x_d, min_y_q, min_y_d;
    logic [9:0]  max_x_q, max_x_d, max_y_q, max_y_d;
    logic [18:0] lit_acc_q, lit_acc_d;
    logic        first_frame_q, first_frame_d;
    logic [9:0]  bbox_left_q, bbox_left_d, bbox_top_q, bbox_top_d;
    logic [9:0]  bbox_right_q, bbox_right_d, bbox_bottom_q, bbox_bottom_d;
    logic [18:0] lit_count_q, lit_count_d;
    logic [7:0]  frame_count_q, frame_count_d;
    logic        frame_valid_q, frame_valid_d;
    logic        frame_empty_q, frame_empty_d;

    always_comb begin
        min_x_d       = min_x_q;
        min_y_d       = min_y_q;
        max_x_d       = max_x_q;
        max_y_d       = max_y_q;
        lit_acc_d     = lit_acc_q;
        first_frame_d = first_frame_q;
        bbox_left_d   = bbox_left_q;
        bbox_top_d    = bbox_top_q;
        bbox_right_d  = bbox_right_q;
        bbox_bottom_d = bbox_bottom_q;
        lit_count_d   = lit_count_q;
        frame_count_d = frame_count_q;
        frame_valid_d = 1'b0;
        frame_empty_d = frame_empty_q;
        acc_empty     = (lit_acc_q == '0);

        if (vs_edge) begin
            // The frame ending at the first edge after reset started
            // mid-stream, so it is dropped instead of published.
            if (!first_frame_q) begin
                bbox_left_d   = acc_empty ? 10'd0 : min_x_q;
                bbox_top_d    = acc_empty ? 10'd0 : min_y_q;
                bbox_right_d  = acc_empty ? 10'd0 : max_x_q;
                bbox_bottom_d = acc_empty ? 10'd0 : max_y_q;
                lit_count_d   = lit_acc_q;
                frame_empty_d = acc_empty;
                frame_valid_d = 1'b1;
                frame_count_d = frame_count_q + 8'd1;
            end
            first_frame_d = 1'b0;
            min_x_d       = CNT_MAX;
            min_y_d       = CNT_MAX;
            max_x_d       = '0;
            max_y_d       = '0;
            lit_acc_d     = '0;
        end else if (lit) begin
            if (x < min_x_q) min_x_d = x;
            if (y < min_y_q) min_y_d = y;
            if (x > max_x_q) max_x_d = x;
            if (y > max_y_q) max_y_d = y;
            if (lit_acc_q != LIT_MAX) lit_acc_d = lit_acc_q + 19'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_x_q       <= CNT_MAX;
            min_y_q       <= CNT_MAX;
            max_x_q       <= '0;
            max_y_q       <= '0;
            lit_acc_q     <= '0;
            first_frame_q <= 1'b1;
            bbox_left_q   <= '0;
            bbox_top_q    <= '0;
            bbox_right_q  <= '0;
            bbox_bottom_q <= '0;
            lit_count_q   <= '0;
            frame_count_q <= '0;
            frame_valid_q <= 1'b0;
            frame_empty_q <= 1'b1;
        end else begin
            min_x_q       <= min_x_d;
            min_y_q       <= min_y_d;
            max_x_q       <= max_x_d;
            max_y_q       <= max_y_d;
            lit_acc_q     <= lit_acc_d;
            first_frame_q <= first_frame_d;
            bbox_left_q   <= bbox_left_d;
            bbox_top_q    <= bbox_top_d;
            bbox_right_q  <= bbox_right_d;
            bbox_bottom_q <= bbox_bottom_d;
            lit_count_q   <= lit_count_d;
            frame_count_q <= frame_count_d;
            frame_valid_q <= frame_valid_d;
            frame_empty_q <= frame_empty_d;
        end
    end

    assign bbox_left   = bbox_left_q;
    assign bbox_top    = bbox_top_q;
    assign bbox_right  = bbox_right_q;
    assign bbox_bottom = bbox_bottom_q;
    assign lit_count   = lit_count_q;
    assign frame_count = frame_count_q;
    assign frame_valid = frame_valid_q;
    assign frame_empty = frame_empty_q;

endmodule

// File: tb/tb_vga_frame_analyzer.sv
`timescale 1ns/1ps
// Directed bench for vga_frame_analyzer with default 640x480 timing.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Lines are generated only as long as the content needs, so frames are
// geometrically exact in hcnt/vcnt but short in cycles.
module tb_vga_frame_analyzer;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic [7:0]  vga_in = 8'h88;
    logic [9:0]  bbox_left, bbox_top, bbox_right, bbox_bottom;
    logic [18:0] lit_count;
    logic [7:0]  frame_count;
    logic        frame_valid, frame_empty, h_locked;

    vga_frame_analyzer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .vga_in      (vga_in),
        .bbox_left   (bbox_left),
        .bbox_top    (bbox_top),
        .bbox_right  (bbox_right),
        .bbox_bottom (bbox_bottom),
        .lit_count   (lit_count),
        .frame_count (frame_count),
        .frame_valid (frame_valid),
        .frame_empty (frame_empty),
        .h_locked    (h_locked)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // ---------------- scoreboard ----------------
    // entry: {frame_count[7:0], left, top, right, bottom, lit_count[18:0], empty}
    logic [67:0] exp_q[$];
    logic [67:0] exp_e;
    logic [7:0]  exp_fc   = 8'd0;
    int          n_pushed = 0;
    int          pub_cnt  = 0;
    logic        fv_prev  = 1'b0;

    task automatic push_exp(input int l, input int t, input int r, input int b, input int cnt);
        logic empty;
        empty  = (cnt == 0);
        exp_fc = exp_fc + 8'd1;
        n_pushed++;
        exp_q.push_back({exp_fc, 10'(l), 10'(t), 10'(r), 10'(b), 19'(cnt), empty});
    endtask

    always @(negedge clk) begin
        if (frame_valid) begin
            pub_cnt++;
            check("fv_single_cycle", {31'd0, fv_prev}, 0);
            if (exp_q.size() == 0) begin
                check("unexpected_publish", {31'd0, frame_valid}, 0);
            end else begin
                exp_e = exp_q.pop_front();
                check("pub_frame_count", {24'd0, frame_count}, {24'd0, exp_e[67:60]});
                check("pub_left",        {22'd0, bbox_left},   {22'd0, exp_e[59:50]});
                check("pub_top",         {22'd0, bbox_top},    {22'd0, exp_e[49:40]});
                check("pub_right",       {22'd0, bbox_right},  {22'd0, exp_e[39:30]});
                check("pub_bottom",      {22'd0, bbox_bottom}, {22'd0, exp_e[29:20]});
                check("pub_lit_count",   {13'd0, lit_count},   {13'd0, exp_e[19:1]});
                check("pub_empty",       {31'd0, frame_empty}, {31'd0, exp_e[0]});
            end
        end
        fv_prev = frame_valid;
    end

    // ---------------- drivers ----------------
    function automatic logic [7:0] pmod(input logic hs, input logic vs, input logic [5:0] col);
        return {hs, col[5:3], vs, col[2:0]};
    endfunction

    task automatic drive(input logic [7:0] v);
        @(negedge clk);
        vga_in = v;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(pmod(1'b1, 1'b1, 6'd0));
    endtask

    // One line of n cycles: hsync low on the first cycle (hcnt 0), colour on hcnt lo..hi.
    task automatic line(input int n, input int lo, input int hi, input logic [5:0] col);
        for (int c = 0; c < n; c++)
            drive(pmod(c != 0, 1'b1, (c >= lo && c <= hi) ? col : 6'd0));
    endtask

    task automatic short_lines(input int k);
        for (int i = 0; i < k; i++) line(2, 1, 0, 6'd0);
    endtask

    task automatic vsync_edge();
        drive(pmod(1'b1, 1'b0, 6'd0));
        drive(pmod(1'b1, 1'b1, 6'd0));
    endtask

    // ---------------- stimulus ----------------
    int base;

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check("rst_left",   {22'd0, bbox_left},   0);
        check("rst_top",    {22'd0, bbox_top},    0);
        check("rst_right",  {22'd0, bbox_right},  0);
        check("rst_bottom", {22'd0, bbox_bottom}, 0);
        check("rst_lit",    {13'd0, lit_count},   0);
        check("rst_fc",     {24'd0, frame_count}, 0);
        check("rst_fv",     {31'd0, frame_valid}, 0);
        check("rst_empty",  {31'd0, frame_empty}, 1);
        check("rst_locked", {31'd0, h_locked},    0);
        rst_n = 1'b1;
        idle(4);

        // first edge after reset only clears
        vsync_edge();
        idle(4);
        check("first_edge_no_publish", pub_cnt, 0);

        // logo: 128x128 all-lit block at (200,200): vcnt 235..362, hcnt 344..471
        short_lines(234);
        for (int r = 0; r < 128; r++) line(472, 344, 471, 6'b111111);
        push_exp(200, 200, 327, 327, 16384);
        vsync_edge();
        idle(4);
        check("logo_fc", {24'd0, frame_count}, 1);

        // all-black frame, publish latency and hold-between-publishes
        short_lines(40);
        check("hlock_short_lines", {31'd0, h_locked}, 1);
        line(300, 1, 0, 6'd0);
        check("hold_left", {22'd0, bbox_left}, 200);
        check("hold_lit",  {13'd0, lit_count}, 16384);
        push_exp(0, 0, 0, 0, 0);
        drive(pmod(1'b1, 1'b0, 6'd0));
        drive(pmod(1'b1, 1'b1, 6'd0));
        check("fv_latency_1cyc", {31'd0, frame_valid}, 0);
        @(negedge clk);
        check("fv_latency_2cyc", {31'd0, frame_valid}, 1);
        idle(3);
        check("black_empty", {31'd0, frame_empty}, 1);
        check("black_fc",    {24'd0, frame_count}, 2);

        // corner (0,0); hcnt 143 and vcnt 34 are outside the active area
        short_lines(33);
        line(202, 200, 200, 6'b000001);
        line(146, 143, 144, 6'b100000);
        push_exp(0, 0, 0, 0, 1);
        vsync_edge();
        idle(4);
        check("corner_not_empty", {31'd0, frame_empty}, 0);

        // corner (639,479); hcnt 784 and vcnt 515 are outside the active area
        short_lines(513);
        line(786, 783, 784, 6'b000010);
        line(202, 200, 200, 6'b111111);
        push_exp(639, 479, 639, 479, 1);
        vsync_edge();
        idle(4);

        // reset in the middle of a lit frame
        short_lines(40);
        line(200, 150, 160, 6'b010010);
        rst_n = 1'b0;
        #1;
        check("midrst_left",   {22'd0, bbox_left},   0);
        check("midrst_lit",    {13'd0, lit_count},   0);
        check("midrst_fc",     {24'd0, frame_count}, 0);
        check("midrst_empty",  {31'd0, frame_empty}, 1);
        check("midrst_locked", {31'd0, h_locked},    0);
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        exp_fc = 8'd0;
        idle(4);
        base = pub_cnt;
        vsync_edge();
        idle(4);
        check("rst_edge_no_publish", pub_cnt - base, 0);
        short_lines(39);
        for (int r = 0; r < 2; r++) line(160, 150, 155, 6'b001100);
        push_exp(6, 5, 11, 6, 12);
        vsync_edge();
        idle(4);
        check("rst_then_fc1", {24'd0, frame_count}, 1);

        // 256 publishes: frame_count wraps 255 -> 0
        for (int i = 0; i < 256; i++) begin
            push_exp(0, 0, 0, 0, 0);
            vsync_edge();
            idle(1);
            if (i == 253) check("fc_255", {24'd0, frame_count}, 255);
            if (i == 254) check("fc_wrap_0", {24'd0, frame_count}, 0);
        end
        idle(4);
        check("fc_after_wrap", {24'd0, frame_count}, 1);

        // line-length lock: 800, 800, 801, 801, then hsync halted
        idle(1100);
        check("hlock_idle", {31'd0, h_locked}, 0);
        line(800, 1, 0, 6'd0);
        check("hlock_first_edge", {31'd0, h_locked}, 0);
        line(800, 1, 0, 6'd0);
        check("hlock_one_800", {31'd0, h_locked}, 0);
        line(801, 1, 0, 6'd0);
        check("hlock_two_800", {31'd0, h_locked}, 1);
        line(801, 1, 0, 6'd0);
        check("hlock_first_801", {31'd0, h_locked}, 0);
        line(20, 1, 0, 6'd0);
        check("hlock_second_801", {31'd0, h_locked}, 1);
        idle(1080);
        check("hlock_halt", {31'd0, h_locked}, 0);

        // final report
        idle(4);
        check("scoreboard_drained", exp_q.size(), 0);
        check("publish_count", pub_cnt, n_pushed);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_frame_analyzer.md
VGA_FRAME_ANALYZER -- requirements
Module: vga_frame_analyzer

Interface
REQ-001 SHALL have parameter H_START, default 144, meaning cycles from the hsync assertion edge to active pixel x=0.
REQ-002 SHALL have parameter V_START, default 35, meaning lines from the vsync assertion edge to active line y=0.
REQ-003 SHALL have parameter H_ACTIVE, default 640, meaning active pixels per line.
REQ-004 SHALL have parameter V_ACTIVE, default 480, meaning active lines per frame.
REQ-005 SHALL have port clk, input, 1 bit: the single clock. All logic runs on the rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port vga_in, input, 8 bits: TinyVGA PMOD byte {hsync, B0, G0, R0, vsync, B1, G1, R1}. Syncs are active-low.
REQ-008 SHALL have port bbox_left, output, 10 bits: minimum x of lit pixels in the last frame.
REQ-009 SHALL have port bbox_top, output, 10 bits: minimum y of lit pixels in the last frame.
REQ-010 SHALL have port bbox_right, output, 10 bits: maximum x of lit pixels in the last frame.
REQ-011 SHALL have port bbox_bottom, output, 10 bits: maximum y of lit pixels in the last frame.
REQ-012 SHALL have port lit_count, output, 19 bits: number of lit active pixels in the last frame.
REQ-013 SHALL have port frame_count, output, 8 bits: count of published frames, wrapping.
REQ-014 SHALL have port frame_valid, output, 1 bit: one-cycle pulse when results are published.
REQ-015 SHALL have port frame_empty, output, 1 bit: the last published frame had no lit pixel.
REQ-016 SHALL have port h_locked, output, 1 bit: line period is stable.

Function
REQ-017 SHALL register vga_in once. All logic uses only the registered copy.
REQ-018 SHALL detect an hsync assertion edge when the registered hsync goes 1->0, and a vsync assertion edge when the registered vsync goes 1->0.
REQ-019 SHALL run a 10-bit hcnt:
- set to 0 on the cycle of an hsync edge;
- otherwise increment;
- saturate at 1023.
REQ-020 SHALL run a 10-bit vcnt:
- set to 0 on a vsync edge;
- otherwise increment on each hsync edge;
- saturate at 1023.
- When both edges occur in the same cycle, the vsync edge wins.
REQ-021 SHALL define x = hcnt - H_START and y = vcnt - V_START. A pixel is active only when H_START <= hcnt < H_START+H_ACTIVE and V_START <= vcnt < V_START+V_ACTIVE.
REQ-022 SHALL define lit as active AND any of the six colour bits set.
REQ-023 SHALL update the accumulators on each lit pixel:
- min_x, min_y, max_x, max_y;
- lit accumulator increments and saturates at 2^19-1.
REQ-024 SHALL handle each vsync edge in one cycle:
- copy the accumulators to the outputs;
- set frame_empty = (accumulated lit count == 0);
- pulse frame_valid;
- increment frame_count (mod 256);
- reinitialise the accumulators (min=1023, max=0, count=0).
REQ-025 SHALL drive all four bbox outputs to 0 when a published frame is empty.
REQ-026 SHALL assert frame_valid exactly 2 cycles after the vga_in vsync bit falls (1 input register plus 1 publish register).
REQ-027 SHALL neither pulse frame_valid nor increment frame_count on the first vsync edge after reset. That edge only clears the accumulators, because the frame is partial.
REQ-028 SHALL capture line_len = hcnt+1 at each hsync edge. h_locked goes to 1 when two consecutive line_len values are equal and below 1023.
REQ-029 SHALL clear h_locked when line_len differs from the previous value, or when hcnt reaches 1023.
REQ-030 SHALL hold all outputs stable between publishes.

Reset
REQ-031 SHALL, while rst_n is low, set:
- outputs: bbox_* = 0, lit_count = 0, frame_count = 0, frame_valid = 0, frame_empty = 1, h_locked = 0;
- internal state: input register = 8'hFF (syncs idle), hcnt = vcnt = 1023, accumulators reinitialised, first-frame flag set.
REQ-032 SHALL take effect immediately on rst_n assertion, including mid-frame, and discard any partial accumulation.

Structure
REQ-033 SHALL place shared constants in package vga_pkg: default H_START, V_START, H_ACTIVE, V_ACTIVE, and the PMOD bit positions of hsync, vsync and the colour bits.
REQ-034 SHALL split the timing recovery into one sub-module, vga_timing_recover, covering input register, edge detect, hcnt/vcnt, line_len and h_locked. The top module holds the accumulators and publish logic.

Verification
REQ-035 SHALL cover: the team VGA generator, logo at (200,200), 128x128 all-lit block, 3 frames -> second and later publishes show bbox 200/200/327/327, lit_count 16384, frame_empty 0.
REQ-036 SHALL cover: an all-black frame -> bbox all 0, lit_count 0, frame_empty 1, frame_count increments.
REQ-037 SHALL cover: a single lit pixel at hcnt 144+639, vcnt 35+479 -> bbox 639/479/639/479, lit_count 1. A lit pixel at hcnt 143 is not counted.
REQ-038 SHALL cover: rst_n pulsed low mid-frame -> the next vsync edge gives no frame_valid; the following edge publishes a full frame with frame_count 1.
REQ-039 SHALL cover: 256 frames -> frame_count wraps 255->0, and frame_valid is high for exactly one cycle per publish.
REQ-040 SHALL cover: line lengths 800, 800, 801, 801 -> h_locked rises after the second 800, falls at the first 801, and rises at the second 801. Halting hsync for 1100 cycles -> h_locked 0.
